soc_system_spi_slave: RTL and testbench

SPI responder (slave) for the soc_system fabric, the opposite end of the on-chip SPI master: CPOL=1, CPHA=1, 8 data bits, MSB first. It lets the HPS or a second FPGA act as the SPI target of an external controller. The block oversamples SCLK, SS_n and MOSI in the `clk` domain and shifts one byte per frame. The CPU sees the same register and status layout as the master: rx/tx holding registers and an interrupt.

---
 rtl/soc_system_spi_slave_pkg.sv | 16 +
 rtl/soc_system_spi_slave_sync.sv | 27 ++
 rtl/soc_system_spi_slave.sv | 119 +++++++++++
 tb/tb_soc_system_spi_slave.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/soc_system_spi_slave_pkg.sv
// soc_system_spi_slave_pkg: register map, status/control bit indices and FSM states for the SPI slave
package soc_system_spi_slave_pkg;
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam int B_UDR  = 2;
  localparam int B_ROE  = 3;
  localparam int B_TOE  = 4;
  localparam int B_TMT  = 5;
  localparam int B_TRDY = 6;
  localparam int B_RRDY = 7;
  localparam int B_E    = 8;
  localparam logic [15:0] CTRL_MASK = 16'h01DC;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/soc_system_spi_slave_sync.sv
// soc_system_spi_slave_sync: idle-high multi-stage synchronizer with rise/fall pulses
// Ports: clk, reset (sync, active-high), d (async pin), level (synchronized), rise/fall (one-clk pulses)
module soc_system_spi_slave_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '1;
      prev <= 1'b1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end
  assign level = sr[STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/soc_system_spi_slave.sv
// soc_system_spi_slave: CPOL=1/CPHA=1 SPI slave with rx/tx holding registers, status/control and irq
// Ports: clk, reset; SPI pins SCLK, SS_n, MOSI, MISO, MISO_oe;
//        CPU port mem_addr, spi_select, read_n, write_n, data_from_cpu, data_to_cpu; irq
module soc_system_spi_slave
  import soc_system_spi_slave_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq
);
  state_t state, state_next;
  logic [2:0] bitcnt;
  logic [DATABITS-1:0] shift_reg, rx_holding, tx_holding;
  logic tx_primed, rrdy, roe, toe, udr;
  logic [15:0] ctrl, status, rdata;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s, ss_s, ss_rise, ss_fall, sclk_rise, sclk_fall, unused_sclk_level;
  logic start, stop, shift, frame_done, load;
  logic wr, rd, wr_tx, wr_status, wr_ctrl, rd_rx, trdy, tmt;

  soc_system_spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .d(SCLK),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  soc_system_spi_slave_sync #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .d(SS_n),
    .level(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign start = (state == IDLE) & ss_fall;
  assign stop = (state == ACTIVE) & ss_rise;
  // a deselect in the same clk as an SCLK edge wins: the partial byte is dropped
  assign shift = (state == ACTIVE) & ~ss_rise & sclk_rise;
  assign frame_done = shift & (bitcnt == 3'(DATABITS - 1));
  assign load = start | frame_done;

  assign wr = spi_select & ~write_n;
  assign rd = spi_select & ~read_n;
  assign wr_tx = wr & (mem_addr == ADDR_TXDATA);
  assign wr_status = wr & (mem_addr == ADDR_STATUS);
  assign wr_ctrl = wr & (mem_addr == ADDR_CONTROL);
  assign rd_rx = rd & (mem_addr == ADDR_RXDATA);
  assign trdy = ~tx_primed;
  assign tmt = (state == IDLE) & ~tx_primed;
  assign MISO_oe = ~ss_s;

  always_comb begin
    status = '0;
    status[B_UDR] = udr;
    status[B_ROE] = roe;
    status[B_TOE] = toe;
    status[B_TMT] = tmt;
    status[B_TRDY] = trdy;
    status[B_RRDY] = rrdy;
    status[B_E] = roe | toe | udr;
  end

  assign rdata = (mem_addr == ADDR_RXDATA)  ? {{(16-DATABITS){1'b0}}, rx_holding} :
                 (mem_addr == ADDR_STATUS)  ? status :
                 (mem_addr == ADDR_CONTROL) ? ctrl : 16'h0000;

  always_comb state_next = start ? ACTIVE : stop ? IDLE : state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_sr <= '1;
      bitcnt <= '0;
      shift_reg <= '0;
      rx_holding <= '0;
      tx_holding <= '0;
      tx_primed <= 1'b0;
      rrdy <= 1'b0;
      roe <= 1'b0;
      toe <= 1'b0;
      udr <= 1'b0;
      ctrl <= '0;
      MISO <= 1'b1;
      data_to_cpu <= '0;
      irq <= 1'b0;
    end else begin
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      bitcnt <= start ? 3'd0 : shift ? bitcnt + 3'd1 : bitcnt;
      // an empty holding register sends zeros; a same-clk txdata write stays in holding
      if (load) shift_reg <= tx_primed ? tx_holding : '0;
      else if (shift) shift_reg <= {shift_reg[DATABITS-2:0], mosi_s};
      if ((state == ACTIVE) & ~ss_rise & sclk_fall) MISO <= shift_reg[DATABITS-1];
      if (frame_done) rx_holding <= {shift_reg[DATABITS-2:0], mosi_s};
      if (wr_tx & trdy) tx_holding <= data_from_cpu[DATABITS-1:0];
      tx_primed <= (wr_tx & trdy) | (tx_primed & ~load);
      rrdy <= frame_done | (rrdy & ~rd_rx);
      roe <= (frame_done & rrdy) | (roe & ~wr_status);
      toe <= (wr_tx & ~trdy) | (toe & ~wr_status);
      udr <= (load & ~tx_primed) | (udr & ~wr_status);
      if (wr_ctrl) ctrl <= data_from_cpu & CTRL_MASK;
      if (rd) data_to_cpu <= rdata;
      irq <= |(status & ctrl);
    end
  end
endmodule

// File: tb/tb_soc_system_spi_slave.sv
// tb_soc_system_spi_slave: directed register vectors plus SPI master sequences for the SPI slave
module tb_soc_system_spi_slave;
  localparam int HALF = 25;
  logic clk = 1'b0, reset = 1'b1;
  logic sclk = 1'b1, ss_n = 1'b1, mosi = 1'b1;
  logic miso, miso_oe, irq;
  logic [2:0] mem_addr = '0;
  logic spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [15:0] data_from_cpu = '0, data_to_cpu;
  int total = 0, passed = 0;

  soc_system_spi_slave dut (
    .clk(clk), .reset(reset), .SCLK(sclk), .SS_n(ss_n), .MOSI(mosi),
    .MISO(miso), .MISO_oe(miso_oe), .mem_addr(mem_addr), .spi_select(spi_select),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] q);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    q = data_to_cpu;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] q;
    cpu_read(a, q);
    check(name, q, exp);
  endtask

  // master side: SS_n held low for n bits, data changes on SCLK fall, MISO sampled before rise
  task automatic spi_xfer(input logic [15:0] d, input int n, input int rst_at, output logic [15:0] q);
    q = '0;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    if (rst_at < 0) check("miso_oe_active", {15'd0, miso_oe}, 16'd1);
    for (int i = n - 1; i >= 0; i--) begin
      if (rst_at == n - 1 - i) begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
      sclk = 1'b0; mosi = d[i];
      repeat (HALF) @(negedge clk);
      q = {q[14:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("miso_oe_idle", {15'd0, miso_oe}, 16'd0);
  endtask

  initial begin
    logic [15:0] q, s;
    tbl[0] = '{1'b0, 3'd2, 16'h0000, 16'h0060};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 3'd3, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 3'd3, 16'hFFFF, 16'h0000};
    tbl[4] = '{1'b0, 3'd3, 16'h0000, 16'h01DC};
    tbl[5] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 3'd6, 16'h1234, 16'h0000};
    tbl[7] = '{1'b0, 3'd2, 16'h0000, 16'h0060};
    tbl[8] = '{1'b1, 3'd3, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 3'd3, 16'h0000, 16'h0000};
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_miso", {15'd0, miso}, 16'd1);
    check("reset_miso_oe", {15'd0, miso_oe}, 16'd0);
    check("reset_irq", {15'd0, irq}, 16'd0);
    check("reset_data_to_cpu", data_to_cpu, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) cpu_write(tbl[i].addr, tbl[i].wdata);
      else read_check($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
    end
    cpu_write(3'd3, 16'h0040);
    @(negedge clk);
    check("irq_trdy", {15'd0, irq}, 16'd1);
    cpu_write(3'd3, 16'h0000);
    @(negedge clk);
    check("irq_off", {15'd0, irq}, 16'd0);

    cpu_write(3'd1, 16'h00A5);
    read_check("status_primed", 3'd2, 16'h0000);
    spi_xfer(16'h003C, 8, -1, q);
    check("miso_a5", q, 16'h00A5);
    read_check("status_frame1", 3'd2, 16'h01E4);
    read_check("rx_3c", 3'd0, 16'h003C);
    read_check("status_rrdy_cleared", 3'd2, 16'h0164);
    cpu_write(3'd2, 16'h0000);
    read_check("status_cleared", 3'd2, 16'h0060);

    spi_xfer(16'h5AC3, 16, -1, q);
    check("miso_underrun", q, 16'h0000);
    read_check("status_b2b", 3'd2, 16'h01EC);
    cpu_write(3'd2, 16'h0000);
    read_check("status_b2b_clr", 3'd2, 16'h00E0);
    read_check("rx_c3", 3'd0, 16'h00C3);
    read_check("status_b2b_idle", 3'd2, 16'h0060);

    cpu_write(3'd3, 16'h0010);
    cpu_write(3'd1, 16'h0011);
    cpu_write(3'd1, 16'h0022);
    check("irq_toe_early", {15'd0, irq}, 16'd0);
    @(negedge clk);
    check("irq_toe", {15'd0, irq}, 16'd1);
    spi_xfer(16'h0077, 8, -1, q);
    check("miso_11", q, 16'h0011);
    read_check("status_toe", 3'd2, 16'h01F4);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0000);
    read_check("status_toe_clr", 3'd2, 16'h00E0);
    read_check("rx_77", 3'd0, 16'h0077);

    spi_xfer(16'h001F, 5, -1, q);
    read_check("status_partial", 3'd2, 16'h0164);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd1, 16'h0096);
    spi_xfer(16'h00E1, 8, -1, q);
    check("miso_96", q, 16'h0096);
    read_check("rx_e1", 3'd0, 16'h00E1);
    cpu_write(3'd2, 16'h0000);

    spi_xfer(16'h00FF, 8, 3, q);
    cpu_read(3'd2, s);
    check("rrdy_after_reset", s & 16'h0080, 16'h0000);
    cpu_write(3'd2, 16'h0000);
    spi_xfer(16'h003A, 8, -1, q);
    check("miso_after_reset", q, 16'h0000);
    read_check("rx_3a", 3'd0, 16'h003A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
